decode_stage_param: RTL

// Parametrised pipelined decode stage; successor to the fixed 18-bit Decode stage. Splits an

---
 rtl/decode_stage_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/decode_stage_param.sv
// Parametrised pipelined decode stage: splits an instruction into fn/op1/op2,
// tags it with the PC counter, and reads register operands with write-back
// forwarding. Valid/ready on both sides, flush redirects the PC counter.
module decode_stage_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FN_W   = 2,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned PC_W   = 8,
    localparam int unsigned INSTR_W = FN_W + 1 + 2 * DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc,
    output logic [DATA_W-1:0]  op1,
    output logic [DATA_W-1:0]  op2,
    output logic [FN_W-1:0]    fn,
    output logic               err,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc
);

    localparam int unsigned NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic              out_valid_q, out_valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [FN_W-1:0]   fn_q, fn_d;
    logic              err_q, err_d;

    logic [FN_W-1:0]   fn_f;
    logic              mode_f;
    logic [DATA_W-1:0] a_fld;
    logic [DATA_W-1:0] b_fld;
    logic [REG_AW-1:0] a_idx;
    logic [REG_AW-1:0] b_idx;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              idx_err;
    logic              accept;

    // Field extraction: {fn, mode, a_fld, b_fld}
    assign fn_f   = instr[INSTR_W-1 -: FN_W];
    assign mode_f = instr[2*DATA_W];
    assign a_fld  = instr[2*DATA_W-1 -: DATA_W];
    assign b_fld  = instr[DATA_W-1:0];
    assign a_idx  = a_fld[REG_AW-1:0];
    assign b_idx  = b_fld[REG_AW-1:0];

    // Flush blocks acceptance; otherwise accept when the output slot frees up
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Register reads with same-cycle write-back forwarding; R0 reads zero
    always_comb begin
        rd_a    = '0;
        rd_b    = '0;
        idx_err = (|(a_fld >> REG_AW)) || (|(b_fld >> REG_AW));
        if (a_idx != '0) begin
            rd_a = (wb_en && wb_addr == a_idx) ? wb_data : regs_q[a_idx];
        end
        if (b_idx != '0) begin
            rd_b = (wb_en && wb_addr == b_idx) ? wb_data : regs_q[b_idx];
        end
    end

    // Register file write port; writes to R0 are dropped
    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != '0) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Output slot and PC counter next-state; flush wins over accept
    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        fn_d        = fn_q;
        err_d       = err_q;
        if (flush) begin
            out_valid_d = 1'b0;
            cnt_d       = flush_pc;
        end else if (accept) begin
            out_valid_d = 1'b1;
            pc_d        = cnt_q;
            cnt_d       = cnt_q + PC_W'(1);
            fn_d        = fn_f;
            if (mode_f) begin
                op1_d = rd_a;
                op2_d = rd_b;
                err_d = idx_err;
            end else begin
                op1_d = a_fld;
                op2_d = b_fld;
                err_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            cnt_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            fn_q        <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            fn_q        <= fn_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign fn        = fn_q;
    assign err       = err_q;

endmodule
